// File: rtl/sift_pkg.sv
// Shared definitions for the keypoint stream: word layout, trailer limits, frame FSM states.
package sift_pkg;

  localparam int unsigned WordWidth  = 32;
  localparam int unsigned TypeBit    = 31;  // 0 = keypoint, 1 = frame trailer
  localparam int unsigned HiOffset   = 16;  // row (keypoint) or drop count (trailer)
  localparam int unsigned HiWidth    = 15;
  localparam int unsigned LoOffset   = 0;   // col (keypoint) or keypoint count (trailer)
  localparam int unsigned LoWidth    = 16;

  localparam int unsigned DropSatMax = 32767;
  localparam int unsigned KeySatMax  = 65535;

  typedef struct packed {
    logic               is_trailer;
    logic [HiWidth-1:0] hi;
    logic [LoWidth-1:0] lo;
  } key_word_t;

  typedef enum logic [0:0] {
    StScan,
    StFlush
  } frame_state_e;

endpackage

// File: rtl/key_fifo.sv
// Synchronous first-word-fall-through FIFO with occupancy output.
// The head word is visible the cycle after it is pushed; the output reads zero when empty.
module key_fifo #(
  parameter int unsigned Width = 32,
  parameter int unsigned Depth = 64
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [Width-1:0]           push_data,
  input  logic                       pop,
  output logic                       head_valid,
  output logic [Width-1:0]           head_data,
  output logic [$clog2(Depth+1)-1:0] occupancy
);

  localparam int unsigned AddrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW  = $clog2(Depth + 1);
  localparam logic [CntW-1:0] FullCnt = CntW'(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [AddrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q;
  logic             do_push, do_pop;

  // A push into a full FIFO is only taken when a pop frees the slot in the same cycle.
  always_comb begin
    do_pop     = pop && (count_q != '0);
    do_push    = push && ((count_q != FullCnt) || do_pop);
    head_valid = (count_q != '0);
    head_data  = head_valid ? mem_q[rd_ptr_q] : '0;
    occupancy  = count_q;
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

  // Pointers and occupancy.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AddrW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AddrW'(1);
      if (do_push && !do_pop)      count_q <= count_q + CntW'(1);
      else if (do_pop && !do_push) count_q <= count_q - CntW'(1);
    end
  end

endmodule

// File: rtl/key_point_collector.sv
// Collects DoG extremum marks from a raster stream into keypoint words, appends a per-frame
// trailer with saturated keypoint/drop counts, and streams them out over AXI-Stream.
// Optional build macro KEY_BORDER_REJECT_EN: ignore marks on the outermost rows and columns.
module key_point_collector
  import sift_pkg::*;
#(
  parameter int unsigned IMAGE_COLUMN   = 512,
  parameter int unsigned IMAGE_ROW      = 512,
  parameter int unsigned KEY_FIFO_DEPTH = 64
) (
  input  logic        axi_clk,
  input  logic        axi_rst,
  input  logic        key_valid,
  input  logic        key_mark,
  output logic [31:0] m_axis_tdata,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic        m_axis_tlast,
  output logic        key_overflow
);

  localparam int unsigned ColW     = (IMAGE_COLUMN > 1) ? $clog2(IMAGE_COLUMN) : 1;
  localparam int unsigned RowW     = (IMAGE_ROW > 1) ? $clog2(IMAGE_ROW) : 1;
  localparam int unsigned FifoCntW = $clog2(KEY_FIFO_DEPTH + 1);

  localparam logic [ColW-1:0]     LastCol  = ColW'(IMAGE_COLUMN - 1);
  localparam logic [RowW-1:0]     LastRow  = RowW'(IMAGE_ROW - 1);
  localparam logic [FifoCntW-1:0] KeyLimit = FifoCntW'(KEY_FIFO_DEPTH - 1);
  localparam logic [LoWidth-1:0]  KeySat   = LoWidth'(KeySatMax);
  localparam logic [HiWidth-1:0]  DropSat  = HiWidth'(DropSatMax);

  logic [ColW-1:0]    col_q, col_d;
  logic [RowW-1:0]    row_q, row_d;
  logic [LoWidth-1:0] kp_cnt_q, kp_cnt_d, kp_base;
  logic [HiWidth-1:0] drop_cnt_q, drop_cnt_d, drop_base;
  logic               frame_done_q;
  logic               ovf_q;
  frame_state_e       state_q, state_d;

  logic               last_col, last_row, last_pixel, border, mark_ok, room;
  logic               kp_push, kp_drop, fifo_push, fifo_pop, trailer_pop;
  key_word_t          push_word;
  logic               head_valid;
  logic [31:0]        head_data;
  logic [FifoCntW-1:0] occupancy;

  key_fifo #(
    .Width (WordWidth),
    .Depth (KEY_FIFO_DEPTH)
  ) u_key_fifo (
    .clk        (axi_clk),
    .rst_n      (axi_rst),
    .push       (fifo_push),
    .push_data  (push_word),
    .pop        (fifo_pop),
    .head_valid (head_valid),
    .head_data  (head_data),
    .occupancy  (occupancy)
  );

  // Pixel classification, word formatting, counter and FSM next state.
  always_comb begin
    last_col   = (col_q == LastCol);
    last_row   = (row_q == LastRow);
    last_pixel = key_valid && last_col && last_row;
`ifdef KEY_BORDER_REJECT_EN
    border     = (row_q == '0) || last_row || (col_q == '0) || last_col;
`else
    border     = 1'b0;
`endif
    // The last pixel carries the trailer, so its mark is never taken.
    mark_ok    = key_valid && key_mark && !last_pixel && !border;
    // Keep one slot free so the trailer always fits.
    room       = (occupancy < KeyLimit);
    kp_push    = mark_ok && room;
    kp_drop    = mark_ok && !room;

    // Counters read as zero in the cycle after a trailer push; that cycle opens the new frame.
    kp_base    = frame_done_q ? '0 : kp_cnt_q;
    drop_base  = frame_done_q ? '0 : drop_cnt_q;

    push_word            = '0;
    if (last_pixel) begin
      push_word.is_trailer = 1'b1;
      push_word.hi         = drop_base;
      push_word.lo         = kp_base;
    end else begin
      push_word.is_trailer = 1'b0;
      push_word.hi         = HiWidth'(row_q);
      push_word.lo         = LoWidth'(col_q);
    end
    fifo_push   = kp_push || last_pixel;
    fifo_pop    = m_axis_tvalid && m_axis_tready;
    trailer_pop = fifo_pop && m_axis_tlast;

    kp_cnt_d   = kp_base;
    drop_cnt_d = drop_base;
    if (kp_push && (kp_base != KeySat))    kp_cnt_d   = kp_base + LoWidth'(1);
    if (kp_drop && (drop_base != DropSat)) drop_cnt_d = drop_base + HiWidth'(1);

    col_d = col_q;
    row_d = row_q;
    if (key_valid) begin
      if (last_col) begin
        col_d = '0;
        row_d = last_row ? '0 : row_q + RowW'(1);
      end else begin
        col_d = col_q + ColW'(1);
      end
    end

    state_d = state_q;
    unique case (state_q)
      StScan:  if (last_pixel) state_d = StFlush;
      StFlush: if (!last_pixel && trailer_pop) state_d = StScan;
      default: state_d = StScan;
    endcase
  end

  // Raster position, frame counters, overflow pulse and frame state.
  always_ff @(posedge axi_clk) begin
    if (!axi_rst) begin
      col_q        <= '0;
      row_q        <= '0;
      kp_cnt_q     <= '0;
      drop_cnt_q   <= '0;
      frame_done_q <= 1'b0;
      ovf_q        <= 1'b0;
      state_q      <= StScan;
    end else begin
      col_q        <= col_d;
      row_q        <= row_d;
      kp_cnt_q     <= kp_cnt_d;
      drop_cnt_q   <= drop_cnt_d;
      frame_done_q <= last_pixel;
      ovf_q        <= kp_drop;
      state_q      <= state_d;
    end
  end

  // Stream outputs come straight from the FIFO head.
  always_comb begin
    m_axis_tvalid = head_valid;
    m_axis_tdata  = head_data;
    m_axis_tlast  = head_valid && head_data[TypeBit];
    key_overflow  = ovf_q;
  end

`ifndef SYNTHESIS
  // While flushing, at least one trailer is still waiting in the FIFO.
  flush_holds_word : assert property (@(posedge axi_clk) disable iff (!axi_rst)
    (state_q == StFlush) |-> m_axis_tvalid);
`endif

endmodule

// File: tb/tb_key_point_collector.sv
module tb_key_point_collector;

  localparam int unsigned COLS  = 8;
  localparam int unsigned ROWS  = 4;
  localparam int unsigned DEPTH = 4;

  logic        axi_clk = 1'b0;
  logic        axi_rst = 1'b0;
  logic        key_valid = 1'b0;
  logic        key_mark = 1'b0;
  logic        m_axis_tready = 1'b0;
  logic [31:0] m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tlast;
  logic        key_overflow;

  always #5 axi_clk = ~axi_clk;

  key_point_collector #(
    .IMAGE_COLUMN   (COLS),
    .IMAGE_ROW      (ROWS),
    .KEY_FIFO_DEPTH (DEPTH)
  ) dut (
    .axi_clk       (axi_clk),
    .axi_rst       (axi_rst),
    .key_valid     (key_valid),
    .key_mark      (key_mark),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast),
    .key_overflow  (key_overflow)
  );

  int n_checks = 0;
  int n_fails  = 0;

  // Reference model: expected output queue plus frame bookkeeping.
  logic [31:0] mq[$];
  logic [31:0] got[$];
  logic [31:0] exp_q[$];
  int          m_row, m_col, m_kp, m_drop;
  bit          exp_ovf;
  int          ovf_seen;

  function automatic bit eligible(input int r, input int c);
`ifdef KEY_BORDER_REJECT_EN
    return !(r == 0 || r == ROWS - 1 || c == 0 || c == COLS - 1);
`else
    return 1'b1;
`endif
  endfunction

  function automatic void model_reset();
    mq.delete();
    m_row = 0; m_col = 0; m_kp = 0; m_drop = 0;
    exp_ovf = 1'b0;
  endfunction

  // One clock: drive inputs, check outputs against the model, then advance the model.
  task automatic cycle(input bit rst_n, input bit v, input bit m, input bit r);
    logic [31:0] e_data;
    bit          e_valid, e_last, pop, push, new_ovf;
    logic [31:0] word;
    int          occ;
    @(negedge axi_clk);
    axi_rst = rst_n; key_valid = v; key_mark = m; m_axis_tready = r;
    e_valid = (mq.size() > 0);
    e_data  = e_valid ? mq[0] : 32'h0;
    e_last  = e_valid && e_data[31];
    n_checks++;
    if (m_axis_tvalid !== e_valid) begin
      n_fails++; $display("FAIL tvalid: got %b want %b at %0t", m_axis_tvalid, e_valid, $time);
    end
    n_checks++;
    if (m_axis_tdata !== e_data) begin
      n_fails++; $display("FAIL tdata: got %h want %h at %0t", m_axis_tdata, e_data, $time);
    end
    n_checks++;
    if (m_axis_tlast !== e_last) begin
      n_fails++; $display("FAIL tlast: got %b want %b at %0t", m_axis_tlast, e_last, $time);
    end
    n_checks++;
    if (key_overflow !== exp_ovf) begin
      n_fails++; $display("FAIL overflow: got %b want %b at %0t", key_overflow, exp_ovf, $time);
    end
    if (key_overflow === 1'b1) ovf_seen++;
    if (rst_n && m_axis_tvalid === 1'b1 && r) got.push_back(m_axis_tdata);

    if (!rst_n) begin
      model_reset();
    end else begin
      occ = mq.size();
      pop = (occ > 0) && r;
      push = 1'b0; new_ovf = 1'b0; word = 32'h0;
      if (v) begin
        if (m_row == ROWS - 1 && m_col == COLS - 1) begin
          word = {1'b1, 15'(m_drop), 16'(m_kp)};
          push = (occ < DEPTH) || pop;
          m_kp = 0; m_drop = 0;
        end else if (m && eligible(m_row, m_col)) begin
          if (occ < DEPTH - 1) begin
            word = {1'b0, 15'(m_row), 16'(m_col)};
            push = 1'b1;
            if (m_kp < 65535) m_kp++;
          end else begin
            new_ovf = 1'b1;
            if (m_drop < 32767) m_drop++;
          end
        end
        m_col++;
        if (m_col == COLS) begin
          m_col = 0;
          m_row = (m_row == ROWS - 1) ? 0 : m_row + 1;
        end
      end
      if (pop) void'(mq.pop_front());
      if (push) mq.push_back(word);
      exp_ovf = new_ovf;
    end
  endtask

  // Drive n consecutive valid pixels; marks is indexed by raster position. rmode 2 = random ready.
  task automatic drive_pixels(input logic [31:0] marks, input int n, input int rmode);
    for (int i = 0; i < n; i++) begin
      int p;
      p = m_row * COLS + m_col;
      cycle(1'b1, 1'b1, marks[p], (rmode == 2) ? 1'($urandom_range(0, 1)) : 1'(rmode));
    end
  endtask

  task automatic idle(input int n, input bit r);
    for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, 1'b0, r);
  endtask

  task automatic test_reset();
    axi_rst = 1'b0; key_valid = 1'b1; key_mark = 1'b1; m_axis_tready = 1'b1;
    repeat (3) @(posedge axi_clk);
    model_reset();
    cycle(1'b0, 1'b1, 1'b1, 1'b1);
    cycle(1'b1, 1'b0, 1'b0, 1'b1);
    cycle(1'b1, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_basic();
    logic [31:0] marks;
    got.delete();
    marks = (32'd1 << 10) | (32'd1 << 21);
    drive_pixels(marks, 32, 1);
    idle(6, 1'b1);
    exp_q = '{32'h00010002, 32'h00020005, 32'h80000002};
    n_checks++;
    if (got.size() != exp_q.size()) begin
      n_fails++; $display("FAIL basic count: got %0d want %0d", got.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        n_checks++;
        if (got[i] !== exp_q[i]) begin
          n_fails++; $display("FAIL basic word %0d: got %h want %h", i, got[i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_overflow();
    logic [31:0] marks;
    got.delete();
    ovf_seen = 0;
    marks = (32'd1 << 9) | (32'd1 << 10) | (32'd1 << 11) | (32'd1 << 12);
    drive_pixels(marks, 32, 0);
    n_checks++;
    if (ovf_seen != 1) begin
      n_fails++; $display("FAIL overflow pulses: got %0d want 1", ovf_seen);
    end
    idle(8, 1'b1);
    exp_q = '{32'h00010001, 32'h00010002, 32'h00010003, 32'h80010003};
    n_checks++;
    if (got.size() != exp_q.size()) begin
      n_fails++; $display("FAIL overflow count: got %0d want %0d", got.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        n_checks++;
        if (got[i] !== exp_q[i]) begin
          n_fails++; $display("FAIL overflow word %0d: got %h want %h", i, got[i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_last_pixel();
    logic [31:0] marks;
    got.delete();
    marks = 32'd1 << 31;
    drive_pixels(marks, 32, 1);
    idle(4, 1'b1);
    n_checks++;
    if (got.size() != 1 || got[0] !== 32'h80000000) begin
      n_fails++;
      $display("FAIL last pixel: got %0d words first %h want 1 word 80000000", got.size(),
               (got.size() > 0) ? got[0] : 32'h0);
    end
    got.delete();
    marks = (32'd1 << 0) | (32'd1 << 9);
    drive_pixels(marks, 32, 1);
    idle(6, 1'b1);
`ifdef KEY_BORDER_REJECT_EN
    exp_q = '{32'h00010001, 32'h80000001};
`else
    exp_q = '{32'h00000000, 32'h00010001, 32'h80000002};
`endif
    n_checks++;
    if (got.size() != exp_q.size()) begin
      n_fails++; $display("FAIL next frame count: got %0d want %0d", got.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        n_checks++;
        if (got[i] !== exp_q[i]) begin
          n_fails++; $display("FAIL next frame word %0d: got %h want %h", i, got[i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    int issued[3];
    int ntrl;
    got.delete();
    for (int f = 0; f < 3; f++) begin
      issued[f] = 0;
      for (int p = 0; p < COLS * ROWS; p++) begin
        bit mk;
        mk = ($urandom_range(0, 2) == 0);
        if (mk && p != COLS * ROWS - 1 && eligible(p / COLS, p % COLS)) issued[f]++;
        while ($urandom_range(0, 3) == 0)
          cycle(1'b1, 1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        cycle(1'b1, 1'b1, mk, 1'($urandom_range(0, 1)));
      end
    end
    idle(40, 1'b1);
    n_checks++;
    if (mq.size() != 0) begin
      n_fails++; $display("FAIL drain: got %0d words left want 0", mq.size());
    end
    ntrl = 0;
    foreach (got[i]) begin
      if (got[i][31]) begin
        if (ntrl < 3) begin
          n_checks++;
          if (int'(got[i][30:16]) + int'(got[i][15:0]) != issued[ntrl]) begin
            n_fails++;
            $display("FAIL trailer %0d marks: got %0d kept + %0d dropped want %0d total", ntrl,
                     got[i][15:0], got[i][30:16], issued[ntrl]);
          end
        end
        ntrl++;
      end
    end
    n_checks++;
    if (ntrl != 3) begin
      n_fails++; $display("FAIL trailer count: got %0d want 3", ntrl);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] marks;
    marks = (32'd1 << 10) | (32'd1 << 13);
    drive_pixels(marks, 19, 0);
    n_checks++;
    if (mq.size() != 2) begin
      n_fails++; $display("FAIL queued before reset: got %0d want 2", mq.size());
    end
    cycle(1'b0, 1'b1, 1'b1, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, 1'b1);
    got.delete();
    marks = 32'd1 << 11;
    drive_pixels(marks, 32, 1);
    idle(6, 1'b1);
    exp_q = '{32'h00010003, 32'h80000001};
    n_checks++;
    if (got.size() != exp_q.size()) begin
      n_fails++; $display("FAIL post reset count: got %0d want %0d", got.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        n_checks++;
        if (got[i] !== exp_q[i]) begin
          n_fails++; $display("FAIL post reset word %0d: got %h want %h", i, got[i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_border();
    logic [31:0] marks;
    got.delete();
    marks = (32'd1 << 3) | (32'd1 << 25) | (32'd1 << 8) | (32'd1 << 18);
    drive_pixels(marks, 32, 1);
    idle(8, 1'b1);
`ifdef KEY_BORDER_REJECT_EN
    exp_q = '{32'h00020002, 32'h80000001};
`else
    exp_q = '{32'h00000003, 32'h00010000, 32'h00020002, 32'h00030001, 32'h80000004};
`endif
    n_checks++;
    if (got.size() != exp_q.size()) begin
      n_fails++; $display("FAIL border count: got %0d want %0d", got.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        n_checks++;
        if (got[i] !== exp_q[i]) begin
          n_fails++; $display("FAIL border word %0d: got %h want %h", i, got[i], exp_q[i]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_last_pixel();
    test_back_to_back();
    test_reset_mid();
    test_border();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
